// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter (SLL, ROR, SRL, SRA) that moves the operand
// at most STEP bit positions per clock, trading latency for a narrow shift
// network. Operand in and result out use valid/ready handshakes.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (accepted only while idle)
//   funct                00 SLL, 01 ROR, 10 SRL, 11 SRA
//   a, N                 operand and shift/rotate amount (0..WIDTH-1)
//   busy                 operation in progress (shifting or holding result)
//   out_valid/out_ready  result handshake; R is held until taken
//   R                    registered result
module seq_shifter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1,
   localparam int SHW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [SHW-1:0]   N,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] R
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_ROR = 2'b01;
   localparam logic [1:0] OP_SRL = 2'b10;
   localparam logic [1:0] OP_SRA = 2'b11;

   // One extra bit so STEP == WIDTH is representable in the compare.
   localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);
   localparam logic [SHW:0] WID_W  = (SHW+1)'(WIDTH);

   state_t           state, nxt;
   logic [WIDTH-1:0] r, r_nxt;
   logic [SHW-1:0]   cnt, k;
   logic [1:0]       op;
   logic             sign;

   logic [WIDTH-1:0] fill;
   logic [SHW:0]     rsh;

   // k = min(cnt, STEP). When STEP == WIDTH the else-branch is unreachable
   // because cnt never exceeds WIDTH-1.
   always_comb begin
      k = ({1'b0, cnt} < STEP_W) ? cnt : STEP_W[SHW-1:0];
   end

   // One k-position step of the latched operation. k is never 0 in SHIFT,
   // so the rotate's left term never shifts by the full width.
   always_comb begin
      fill  = ~({WIDTH{1'b1}} >> k);
      rsh   = WID_W - {1'b0, k};
      r_nxt = r;
      case (op)
         OP_SLL: r_nxt = r << k;
         OP_ROR: r_nxt = (r >> k) | (r << rsh);
         OP_SRL: r_nxt = r >> k;
         OP_SRA: r_nxt = (r >> k) | (fill & {WIDTH{sign}});
         default: r_nxt = r;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (in_valid) nxt = (N != '0) ? SHIFT : DONE;
         SHIFT:   if (cnt == k) nxt = DONE;
         DONE:    if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Datapath: operands are captured only on the accept edge; sign is kept
   // separately so SRA fills from the original MSB.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r    <= '0;
         cnt  <= '0;
         op   <= '0;
         sign <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               r    <= a;
               cnt  <= N;
               op   <= funct;
               sign <= a[WIDTH-1];
            end
            SHIFT: begin
               r   <= r_nxt;
               cnt <= cnt - k;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE) & ~reset;
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign R         = r;

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: two instances (STEP=1 and STEP=4) share stimulus and
// are checked against a single-shot shift/rotate reference for result,
// latency, backpressure hold and mid-operation reset.
module tb_seq_shifter;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [1:0]  funct;
   logic [31:0] a;
   logic [4:0]  n;
   logic        out_ready;

   logic        ir1, b1, ov1, ir4, b4, ov4;
   logic [31:0] r1, r4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_shifter #(.WIDTH(32), .STEP(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
      .funct(funct), .a(a), .N(n), .busy(b1), .out_valid(ov1),
      .out_ready(out_ready), .R(r1));

   seq_shifter #(.WIDTH(32), .STEP(4)) u4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4),
      .funct(funct), .a(a), .N(n), .busy(b4), .out_valid(ov4),
      .out_ready(out_ready), .R(r4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Single-shot reference: the whole shift by s in one go.
   function automatic logic [31:0] ref_op(input logic [1:0] f, input logic [31:0] x, input int s);
      logic [63:0] d;
      case (f)
         2'b00: return x << s;
         2'b01: begin d = {x, x} >> s; return d[31:0]; end
         2'b10: return x >> s;
         default: return $unsigned($signed(x) >>> s);
      endcase
   endfunction

   task automatic run_op(input logic [1:0] f, input logic [31:0] av, input logic [4:0] nv, input int hold);
      logic [31:0] exp;
      int e1, e4;
      bit d1, d4;
      exp = ref_op(f, av, int'(nv));
      e1  = (nv == 0) ? 0 : int'(nv);
      e4  = (nv == 0) ? 0 : (int'(nv) + 3) / 4;
      @(negedge clk);
      chk("in_ready1", 32'(ir1), 32'd1);
      chk("in_ready4", 32'(ir4), 32'd1);
      funct = f; a = av; n = nv; in_valid = 1'b1;
      @(posedge clk); #1;
      // Scramble inputs after the accept edge; they must be ignored.
      in_valid = 1'b0; funct = 2'($urandom); a = $urandom; n = 5'($urandom);
      d1 = 0; d4 = 0;
      for (int c = 0; c <= 40; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (d1) chk("hold_r1", r1, exp);
         else if (ov1) begin
            d1 = 1; chk("lat1", 32'(c), 32'(e1)); chk("r1", r1, exp);
         end else chk("busy1", 32'({b1, ir1}), 32'b10);
         if (d4) chk("hold_r4", r4, exp);
         else if (ov4) begin
            d4 = 1; chk("lat4", 32'(c), 32'(e4)); chk("r4", r4, exp);
         end else chk("busy4", 32'({b4, ir4}), 32'b10);
         if (d1 && d4) break;
      end
      chk("done1", 32'(d1), 32'd1);
      chk("done4", 32'(d4), 32'd1);
      repeat (hold) begin
         @(posedge clk); #1;
         chk("bp_r1", r1, exp); chk("bp_st1", 32'({ov1, b1, ir1}), 32'b110);
         chk("bp_r4", r4, exp); chk("bp_st4", 32'({ov4, b4, ir4}), 32'b110);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("idle1", 32'({ov1, b1, ir1}), 32'b001);
      chk("idle4", 32'({ov4, b4, ir4}), 32'b001);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; funct = '0; a = '0; n = '0; out_ready = 1'b0;
      #2;
      chk("rst_r1",  r1, 32'd0);
      chk("rst_st1", 32'({ov1, b1}), 32'd0);
      chk("rst_r4",  r4, 32'd0);
      chk("rst_st4", 32'({ov4, b4}), 32'd0);
      @(negedge clk); reset = 1'b0; #1;
      chk("rel_ready1", 32'(ir1), 32'd1);
      chk("rel_ready4", 32'(ir4), 32'd1);

      run_op(2'b00, 32'h0000_0001, 5'd31, 0);
      run_op(2'b11, 32'h8000_0000, 5'd4, 0);
      run_op(2'b10, 32'h8000_0000, 5'd4, 0);
      run_op(2'b01, 32'h0000_00FF, 5'd8, 0);
      run_op(2'b01, 32'h1234_5678, 5'd4, 0);
      run_op(2'b00, 32'h0000_0003, 5'd9, 10);
      run_op(2'b11, 32'hDEAD_BEEF, 5'd0, 2);
      run_op(2'b11, 32'h8000_0001, 5'd31, 0);
      run_op(2'b01, 32'hA5A5_0F0F, 5'd31, 1);

      // Reset in the middle of a shift discards the operation immediately.
      @(negedge clk);
      funct = 2'b00; a = 32'hFFFF_FFFF; n = 5'd20; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_r1",  r1, 32'd0);
      chk("mid_rst_st1", 32'({ov1, b1}), 32'd0);
      chk("mid_rst_r4",  r4, 32'd0);
      chk("mid_rst_st4", 32'({ov4, b4}), 32'd0);
      @(negedge clk); reset = 1'b0;
      run_op(2'b11, 32'h9000_0000, 5'd3, 0);

      for (int i = 0; i < 24; i++)
         run_op(2'($urandom), $urandom, 5'($urandom), int'($urandom_range(0, 3)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case something stalls outside the bounded loops.
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
